// File: rtl/carbon_sim_ctrl_pkg.sv
// Shared definitions for the simulation-control I/O target: register offsets,
// power-state encoding and the default power-off magic byte.
package carbon_sim_pkg;

    localparam logic [2:0] SIM_SIG0   = 3'd0;
    localparam logic [2:0] SIM_SIG1   = 3'd1;
    localparam logic [2:0] SIM_SIG2   = 3'd2;
    localparam logic [2:0] SIM_SIG3   = 3'd3;
    localparam logic [2:0] SIM_CTRL   = 3'd4;
    localparam logic [2:0] SIM_CON_TX = 3'd5;
    localparam logic [2:0] SIM_STATUS = 3'd6;

    localparam logic [7:0] SIM_MAGIC_DEFAULT = 8'h5A;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        OFF   = 2'd2
    } sim_pwr_e;

    // Byte lane of the committed signature; lane 0 is bits [7:0].
    function automatic logic [7:0] sig_byte(input logic [31:0] sig, input logic [1:0] idx);
        return sig[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/carbon_sim_ctrl_if.sv
// CPU I/O bus plus console byte stream seen by the simulation-control block.
interface carbon_sim_ctrl_if;
    logic       io_req;
    logic       io_we;
    logic [7:0] io_addr;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;
    logic       io_ack;
    logic       con_valid;
    logic [7:0] con_data;
    logic       con_ready;

    modport master (
        output io_req, io_we, io_addr, io_wdata, con_ready,
        input  io_rdata, io_ack, con_valid, con_data
    );

    modport slave (
        input  io_req, io_we, io_addr, io_wdata, con_ready,
        output io_rdata, io_ack, con_valid, con_data
    );
endinterface

// File: rtl/carbon_sync_fifo.sv
// Parameterised synchronous FIFO with fall-through head and occupancy count.
module carbon_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/carbon_sim_ctrl.sv
// Simulation-control I/O target: signature commit, console FIFO and a
// power-off request that waits for the console to drain.
module carbon_sim_ctrl
    import carbon_sim_pkg::*;
#(
    parameter logic [7:0] BASE_PORT      = 8'hF0,
    parameter int         CON_DEPTH      = 8,
    parameter logic [7:0] POWEROFF_MAGIC = SIM_MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    carbon_sim_ctrl_if.slave  bus,
    output logic [31:0]       signature,
    output logic              poweroff
);

    localparam int CW = $clog2(CON_DEPTH + 1);

    sim_pwr_e        pwr, pwr_nxt;
    logic [2:0][7:0] shadow;
    logic            ack;
    logic [7:0]      rdata;
    logic [7:0]      rd_mux;

    logic [7:0]      off_full;
    logic [2:0]      off;
    logic            in_window;
    logic            running;
    logic            push_stall;
    logic            accept;
    logic            wr_acc;

    logic            fifo_push;
    logic            fifo_pop;
    logic [7:0]      fifo_head;
    logic            fifo_empty;
    logic            fifo_full;
    logic [CW-1:0]   fifo_count;
    logic [3:0]      occ;

    // Address decode; the lower-bound test keeps the subtraction from wrapping.
    assign off_full  = bus.io_addr - BASE_PORT;
    assign off       = off_full[2:0];
    assign in_window = (bus.io_addr >= BASE_PORT) && (off_full <= 8'd6);
    assign running   = (pwr == RUN);

    assign fifo_pop   = !fifo_empty && bus.con_ready;
    assign push_stall = bus.io_we && (off == SIM_CON_TX) && running && fifo_full && !fifo_pop;
    assign accept     = bus.io_req && in_window && !ack && !push_stall;
    assign wr_acc     = accept && bus.io_we;
    assign fifo_push  = wr_acc && (off == SIM_CON_TX) && running;
    assign occ        = 4'(fifo_count);

    carbon_sync_fifo #(
        .WIDTH (8),
        .DEPTH (CON_DEPTH)
    ) u_con_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (bus.io_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        rd_mux = 8'h00;
        case (off)
            SIM_SIG0, SIM_SIG1, SIM_SIG2, SIM_SIG3:
                rd_mux = sig_byte(signature, off[1:0]);
            SIM_STATUS:
                rd_mux = {occ, poweroff, (pwr == DRAIN), fifo_full, fifo_empty};
            default:
                rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack       <= 1'b0;
            rdata     <= 8'h00;
            shadow    <= '0;
            signature <= 32'h0;
        end else begin
            ack   <= accept;
            rdata <= (accept && !bus.io_we) ? rd_mux : 8'h00;
            // Signature bytes are frozen once power-off has been requested.
            if (wr_acc && running) begin
                case (off)
                    SIM_SIG0: shadow[0] <= bus.io_wdata;
                    SIM_SIG1: shadow[1] <= bus.io_wdata;
                    SIM_SIG2: shadow[2] <= bus.io_wdata;
                    SIM_SIG3: signature <= {bus.io_wdata, shadow[2], shadow[1], shadow[0]};
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) pwr <= RUN;
        else     pwr <= pwr_nxt;
    end

    always_comb begin
        pwr_nxt = pwr;
        case (pwr)
            RUN:
                if (wr_acc && (off == SIM_CTRL) && (bus.io_wdata == POWEROFF_MAGIC))
                    pwr_nxt = DRAIN;
            DRAIN:
                if (fifo_empty) pwr_nxt = OFF;
            OFF:
                pwr_nxt = OFF;
            default:
                pwr_nxt = RUN;
        endcase
    end

    assign poweroff      = (pwr == OFF);
    assign bus.io_ack    = ack;
    assign bus.io_rdata  = rdata;
    assign bus.con_valid = !fifo_empty;
    assign bus.con_data  = fifo_empty ? 8'h00 : fifo_head;

endmodule

// File: tb/tb_carbon_sim_ctrl.sv
// Directed self-checking bench for carbon_sim_ctrl.
module tb_carbon_sim_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] signature;
    logic        poweroff;
    int          checks;
    int          errors;
    logic [7:0]  popq [$];

    carbon_sim_ctrl_if bus ();

    carbon_sim_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .signature (signature),
        .poweroff  (poweroff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every byte that will be popped at the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.con_valid && bus.con_ready) popq.push_back(bus.con_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_io(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         input int budget, output logic acked, output logic [7:0] rd,
                         output logic [31:0] sig);
        @(posedge clk); #1;
        bus.io_req   = 1'b1;
        bus.io_we    = we;
        bus.io_addr  = addr;
        bus.io_wdata = wdata;
        acked = 1'b0;
        rd    = 8'h00;
        sig   = 32'h0;
        for (int i = 0; i < budget && !acked; i++) begin
            @(negedge clk);
            if (bus.io_ack) begin
                acked = 1'b1;
                rd    = bus.io_rdata;
                sig   = signature;
            end
        end
        @(posedge clk); #1;
        bus.io_req = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        logic        a;
        logic [7:0]  r;
        logic [31:0] s;
        do_io(1'b1, addr, data, 10, a, r, s);
        check($sformatf("wr_ack_%h", addr), 32'(a), 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        logic        a;
        logic [7:0]  r;
        logic [31:0] s;
        do_io(1'b0, addr, 8'h00, 10, a, r, s);
        check({tag, "_ack"}, 32'(a), 32'd1);
        check(tag, 32'(r), 32'(exp));
    endtask

    initial begin
        logic        a;
        logic [7:0]  r;
        logic [31:0] s;
        logic        found;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.io_req = 1'b0; bus.io_we = 1'b0; bus.io_addr = 8'h00; bus.io_wdata = 8'h00;
        bus.con_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sig", signature, 32'h0);
        check("rst_poweroff", 32'(poweroff), 32'd0);
        check("rst_con_valid", 32'(bus.con_valid), 32'd0);
        check("rst_ack", 32'(bus.io_ack), 32'd0);
        check("rst_rdata", 32'(bus.io_rdata), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Signature commit
        wr(8'hF0, 8'h5A);
        wr(8'hF1, 8'h38);
        wr(8'hF2, 8'h30);
        check("sig_before_commit", signature, 32'h0);
        do_io(1'b1, 8'hF3, 8'h21, 10, a, r, s);
        check("sig3_ack", 32'(a), 32'd1);
        check("sig_at_ack", s, 32'h2130385A);
        rd_chk("rd_sig1", 8'hF1, 8'h38);
        rd_chk("rd_sig0", 8'hF0, 8'h5A);

        // Console ordering
        bus.con_ready = 1'b1;
        popq.delete();
        wr(8'hF5, 8'h5A);
        wr(8'hF5, 8'h38);
        wr(8'hF5, 8'h30);
        wr(8'hF5, 8'h21);
        repeat (3) @(negedge clk);
        check("con_count", 32'(popq.size()), 32'd4);
        if (popq.size() == 4) begin
            check("con_b0", 32'(popq[0]), 32'h5A);
            check("con_b1", 32'(popq[1]), 32'h38);
            check("con_b2", 32'(popq[2]), 32'h30);
            check("con_b3", 32'(popq[3]), 32'h21);
        end
        rd_chk("status_drained", 8'hF6, 8'h01);
        bus.con_ready = 1'b0;

        // Backpressure
        popq.delete();
        for (int i = 0; i < 8; i++) wr(8'hF5, 8'h10 + 8'(i));
        rd_chk("status_full", 8'hF6, 8'h82);
        @(posedge clk); #1;
        bus.io_req = 1'b1; bus.io_we = 1'b1; bus.io_addr = 8'hF5; bus.io_wdata = 8'h18;
        a = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.io_ack) a = 1'b1;
        end
        check("bp_no_ack", 32'(a), 32'd0);
        @(posedge clk); #1;
        bus.con_ready = 1'b1;
        @(posedge clk); #1;
        bus.con_ready = 1'b0;
        @(negedge clk);
        check("bp_ack_after_pop", 32'(bus.io_ack), 32'd1);
        @(posedge clk); #1;
        bus.io_req = 1'b0;
        @(negedge clk);
        check("no_double_ack", 32'(bus.io_ack), 32'd0);
        rd_chk("status_still_full", 8'hF6, 8'h82);
        bus.con_ready = 1'b1;
        repeat (12) @(negedge clk);
        bus.con_ready = 1'b0;
        check("bp_pop_count", 32'(popq.size()), 32'd9);
        if (popq.size() == 9) begin
            check("bp_first", 32'(popq[0]), 32'h10);
            check("bp_last", 32'(popq[8]), 32'h18);
        end
        rd_chk("status_bp_drained", 8'hF6, 8'h01);

        // Illegal values
        wr(8'hF4, 8'h00);
        rd_chk("status_ctrl0_run", 8'hF6, 8'h01);
        do_io(1'b1, 8'hF7, 8'hAA, 5, a, r, s);
        check("f7_no_ack", 32'(a), 32'd0);

        // Power-off drain
        wr(8'hF5, 8'hA1);
        wr(8'hF5, 8'hA2);
        wr(8'hF5, 8'hA3);
        wr(8'hF4, 8'h5A);
        rd_chk("status_drain", 8'hF6, 8'h34);
        check("drain_poweroff", 32'(poweroff), 32'd0);
        popq.delete();
        @(posedge clk); #1;
        bus.con_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (!bus.con_valid) found = 1'b1;
        end
        check("drain_empty_seen", 32'(found), 32'd1);
        check("poweroff_at_empty", 32'(poweroff), 32'd0);
        @(negedge clk);
        check("poweroff_rise", 32'(poweroff), 32'd1);
        repeat (5) @(negedge clk);
        check("poweroff_sticky", 32'(poweroff), 32'd1);
        check("drain_pop_count", 32'(popq.size()), 32'd3);
        rd_chk("status_off", 8'hF6, 8'h09);
        wr(8'hF3, 8'hFF);
        check("sig_frozen_off", signature, 32'h2130385A);
        wr(8'hF5, 8'h77);
        rd_chk("status_off_tx_discard", 8'hF6, 8'h09);
        rd_chk("rd_sig3_off", 8'hF3, 8'h21);

        // Reset mid-transaction
        bus.con_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_clears_off", 32'(poweroff), 32'd0);
        for (int i = 0; i < 8; i++) wr(8'hF5, 8'hC0 + 8'(i));
        @(posedge clk); #1;
        bus.io_req = 1'b1; bus.io_we = 1'b1; bus.io_addr = 8'hF5; bus.io_wdata = 8'hC8;
        @(negedge clk);
        check("pend_no_ack", 32'(bus.io_ack), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_pend_no_ack", 32'(bus.io_ack), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.io_req = 1'b0;
        @(negedge clk);
        check("mid_rst_ack", 32'(bus.io_ack), 32'd0);
        check("mid_rst_con_valid", 32'(bus.con_valid), 32'd0);
        check("mid_rst_sig", signature, 32'h0);
        check("mid_rst_poweroff", 32'(poweroff), 32'd0);
        check("mid_rst_rdata", 32'(bus.io_rdata), 32'd0);
        rd_chk("status_after_rst", 8'hF6, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/carbon_sim_ctrl.md
# carbon_sim_ctrl

Simulation-control I/O target on the CarbonZ80 system bus: the CPU-facing end of the `signature`/`poweroff` pair that the system bench monitors. The CPU program builds a 32-bit result signature through byte-wide I/O writes, streams debug characters through a small console FIFO, and requests power-off with a magic byte. Power-off asserts only after the console FIFO has drained. Instantiated inside `carbonz80_top`, which drives its `signature` and `poweroff` ports from this block.

## Interface
- `BASE_PORT`, 8'hF0: first I/O port of the 7-port window.
- `CON_DEPTH`, 8: console FIFO depth, 2..15.
- `POWEROFF_MAGIC`, 8'h5A: CTRL value that requests power-off.
- `clk`  in  1  system clock; sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `io_req`  in  1  I/O cycle request, held until `io_ack`.
- `io_we`  in  1  1 = OUT (write), 0 = IN (read); stable while `io_req`.
- `io_addr`  in  8  I/O port number; stable while `io_req`.
- `io_wdata`  in  8  write data; stable while `io_req`.
- `io_rdata`  out  8  read data; valid in the `io_ack` cycle, 0 otherwise.
- `io_ack`  out  1  one-cycle completion pulse; asserted only for in-window ports.
- `con_valid`  out  1  console byte available.
- `con_data`  out  8  console byte (FIFO head).
- `con_ready`  in  1  console sink accepts; a pop occurs when `con_valid && con_ready`.
- `signature`  out  32  committed signature.
- `poweroff`  out  1  sticky power-off indication.

## Operation
- Port map at offset from `BASE_PORT`:
  - +0..+3 SIG0..SIG3: a write stores the shadow byte; a read returns the committed `signature` byte, with SIG0 = bits [7:0].
  - A SIG3 write commits `{wdata, shadow2, shadow1, shadow0}` to `signature` atomically.
  - +4 CTRL: writing `POWEROFF_MAGIC` requests power-off; other values are ignored; reads return 0.
  - +5 CON_TX: a write pushes a byte; reads return 0.
  - +6 STATUS (read-only): bit0 FIFO empty, bit1 FIFO full, bit2 power-off pending (DRAIN), bit3 `poweroff`, bits [7:4] occupancy. Writes are acked and ignored.
- Ports outside +0..+6 are never acked and leave all state unchanged.
- Power FSM states:
  - RUN → DRAIN on a magic CTRL write.
  - DRAIN → OFF in the first cycle the FIFO is empty. This includes immediately, if the FIFO is already empty, one cycle after the CTRL ack.
  - OFF is terminal until `rst`.
- `poweroff` = 1 only in OFF.
- In DRAIN and OFF, CON_TX and SIG writes are acked but discarded; reads behave normally.
- A CTRL magic write in DRAIN or OFF is acked with no effect.
- Console FIFO: first-word fall-through, so `con_data` is the head whenever `con_valid`.

## Timing
- Reset values:
  - `signature` = 0, shadows = 0, `poweroff` = 0, FSM = RUN, FIFO empty.
  - `con_valid` = 0, `io_ack` = 0, `io_rdata` = 0.
- Accept rule: the request is accepted in the first cycle with `io_req`, in-window address, no ack in the current cycle, and (for CON_TX in RUN) FIFO not full.
  - The `io_ack` pulse arrives exactly 1 cycle after acceptance.
  - State updates (commit, push, FSM transition) are visible in the ack cycle.
- The requester must deassert `io_req` in the cycle after `io_ack`. The block never acks two consecutive cycles, so a held `io_req` is not double-counted.
- CON_TX to a full FIFO: no accept and no ack until space appears; `io_req` stays pending.
  - A same-cycle pop frees space, so accept is allowed when full if `con_ready && con_valid`.
- Simultaneous push and pop: occupancy is unchanged; order is preserved.
- `rst` asserted mid-transaction: all state reinitialises, and no ack is issued for the pending request.
- STATUS read data reflects state at the accept cycle.

## Structure
- Package `carbon_sim_pkg` holds:
  - register offset constants (`SIM_SIG0`..`SIM_STATUS`);
  - the power-state enum `sim_pwr_e` {RUN, DRAIN, OFF};
  - the default magic value.
- Sub-module `carbon_sync_fifo` is a parameterised width/depth synchronous FIFO with a count output, reusable elsewhere in the system.
- The top level holds the address decode, the ack/accept register, the shadows, and the FSM.

## Test plan
- **Signature commit:** write 5A, 38, 30, 21 to F0, F1, F2, F3.
  - `signature` stays 0 until the F3 ack.
  - Then `signature` = 32'h2130385A.
  - Reading F1 returns 8'h38.
- **Console ordering:** push "Z80!" with `con_ready` = 1 → `con_data` emits 5A, 38, 30, 21 in order. STATUS reads 8'h01 after the drain.
- **Backpressure:** `con_ready` = 0, push 9 bytes → the 9th request gets no ack. Raise `con_ready` for one pop → the 9th acks on the next cycle.
- **Power-off drain:**
  - With 3 bytes queued and `con_ready` = 0, write 5A to F4.
  - STATUS then reads bit2 = 1 and `poweroff` = 0.
  - Release `con_ready` → `poweroff` rises the cycle after the FIFO is empty and stays high.
- **Illegal values:** CTRL write 0x00 leaves RUN. A write to port F7 produces no ack. A SIG3 write in OFF leaves `signature` unchanged.
- **Reset mid-cycle:** `rst` asserted while a CON_TX request is pending → no ack, FIFO empty, all outputs at reset values.
